// File: rtl/bus_quota_arbiter.sv
// bus_quota_arbiter: 4-master bus arbiter with round-robin hand-off,
// per-master grant quotas, owner lock and a dead-cycle gap between owners.
// Grants are active-low. When nobody else wants the bus it stays parked on
// the last owner. HANDOVER selects 0..3 dead cycles between owners.
module bus_quota_arbiter #(
  parameter int QUOTA_W   = 8,
  parameter int DEF_QUOTA = 16,
  parameter int HANDOVER  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         m_req_n,
  input  logic [3:0]         m_lock_n,
  output logic [3:0]         m_grnt_n,
  output logic [1:0]         owner,
  output logic               handover,
  output logic               quota_expire,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [QUOTA_W-1:0] cfg_data
);

  typedef enum logic {ST_GRANT = 1'b0, ST_TURN = 1'b1} state_t;

  localparam logic [QUOTA_W-1:0] QUOTA_RST = QUOTA_W'(DEF_QUOTA);
  localparam logic [QUOTA_W-1:0] COUNT_MAX = '1;
  localparam logic [QUOTA_W-1:0] ONE       = QUOTA_W'(1);
  // Index of the last dead cycle; unused when HANDOVER is 0.
  localparam int                 HO_LAST_I = (HANDOVER > 0) ? HANDOVER - 1 : 0;
  localparam logic [1:0]         HO_LAST   = 2'(HO_LAST_I);

  state_t             state_reg, state_next;
  logic [1:0]         owner_reg, owner_next;
  logic [1:0]         next_owner_reg, next_owner_next;
  logic [QUOTA_W-1:0] count_reg, count_next;
  logic [1:0]         turn_cnt_reg, turn_cnt_next;
  logic               quota_expire_reg, quota_expire_next;
  logic [QUOTA_W-1:0] quota_reg [4];

  logic [3:0]         req;
  logic [2:0][1:0]    cand;
  logic [2:0]         cand_req;
  logic [1:0]         rr_owner;
  logic               other_pending;
  logic               own_req;
  logic               own_locked;
  logic [QUOTA_W-1:0] cur_quota;
  logic               expire_hit;
  logic               release_hit;

  assign req = ~m_req_n;

  // Round-robin candidates in scan order: owner+1, owner+2, owner+3.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cand
      assign cand[gi]     = owner_reg + 2'(gi + 1);
      assign cand_req[gi] = req[cand[gi]];
    end
  endgenerate

  // First requesting candidate after the owner wins the next turn.
  always_comb begin
    rr_owner = cand[0];
    if (cand_req[0])      rr_owner = cand[0];
    else if (cand_req[1]) rr_owner = cand[1];
    else if (cand_req[2]) rr_owner = cand[2];
  end

  assign other_pending = |cand_req;
  assign own_req       = req[owner_reg];
  assign own_locked    = ~m_lock_n[owner_reg];
  assign cur_quota     = quota_reg[owner_reg];
  // Quota 0 means unlimited; >= lets a lowered quota take effect at once.
  assign expire_hit    = (cur_quota != '0) && (count_reg >= (cur_quota - ONE)) &&
                         own_req && !own_locked && other_pending;
  assign release_hit   = !own_req && other_pending;

  // Quota table: reset to the default, runtime-writable through the cfg port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) quota_reg[i] <= QUOTA_RST;
    end else if (cfg_we) begin
      quota_reg[cfg_sel] <= cfg_data;
    end
  end

  // State register: owner, counters and the registered expiry pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_GRANT;
      owner_reg        <= 2'd0;
      next_owner_reg   <= 2'd0;
      count_reg        <= '0;
      turn_cnt_reg     <= 2'd0;
      quota_expire_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      owner_reg        <= owner_next;
      next_owner_reg   <= next_owner_next;
      count_reg        <= count_next;
      turn_cnt_reg     <= turn_cnt_next;
      quota_expire_reg <= quota_expire_next;
    end
  end

  // Next-state logic: count grant cycles, decide release/expiry, run the gap.
  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    next_owner_next   = next_owner_reg;
    count_next        = count_reg;
    turn_cnt_next     = turn_cnt_reg;
    quota_expire_next = 1'b0;
    case (state_reg)
      ST_GRANT: begin
        if (own_req && (count_reg != COUNT_MAX)) count_next = count_reg + ONE;
        if (release_hit || expire_hit) begin
          quota_expire_next = expire_hit;
          if (HANDOVER == 0) begin
            // No gap: the new owner takes the bus on this very edge.
            owner_next = rr_owner;
            count_next = '0;
          end else begin
            state_next      = ST_TURN;
            next_owner_next = rr_owner;
            turn_cnt_next   = 2'd0;
          end
        end
      end
      ST_TURN: begin
        if (turn_cnt_reg == HO_LAST) begin
          state_next = ST_GRANT;
          owner_next = next_owner_reg;
          count_next = '0;
        end else begin
          turn_cnt_next = turn_cnt_reg + 2'd1;
        end
      end
      default: state_next = ST_GRANT;
    endcase
  end

  // Outputs: one grant low in GRANT, all high with handover flagged in TURN.
  always_comb begin
    m_grnt_n = 4'hF;
    handover = 1'b0;
    if (state_reg == ST_GRANT) m_grnt_n[owner_reg] = 1'b0;
    else                       handover = 1'b1;
  end

  assign owner        = owner_reg;
  assign quota_expire = quota_expire_reg;

endmodule
